// File: rtl/io_test_pkg.sv
// Shared types and constants for the on-board I/O test sequencer.
package io_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam int unsigned SW_WIDTH_DEF  = 24;
  localparam int unsigned LED_WIDTH_DEF = 24;

  // Position of the CPU mode field inside the switch vector.
  localparam int unsigned MODE_MSB = 23;
  localparam int unsigned MODE_LSB = 21;

endpackage

// File: rtl/io_test_cycle_timer.sv
// Loadable down-counter with a registered zero flag; times reset hold and settle.
module io_test_cycle_timer #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= load_val;
      zero  <= (load_val == '0);
    end else if (count != '0) begin
      count <= count - W'(1);
      zero  <= (count == W'(1));
    end
  end

endmodule

// File: rtl/io_test_sequencer.sv
// Steps the CPU through a table of switch values and checks masked led results.
// Build option: IO_TEST_FAIL_HALT_EN stops the run at the first mismatching step.
module io_test_sequencer
  import io_test_pkg::*;
#(
  parameter int unsigned SW_WIDTH   = SW_WIDTH_DEF,
  parameter int unsigned LED_WIDTH  = LED_WIDTH_DEF,
  parameter int unsigned NUM_STEPS  = 8,
  parameter int unsigned RESET_HOLD = 350,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned CNT_W      = $clog2(NUM_STEPS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_steps,
  input  logic [NUM_STEPS*SW_WIDTH-1:0]  step_sw,
  input  logic [NUM_STEPS*LED_WIDTH-1:0] step_exp,
  input  logic [NUM_STEPS*LED_WIDTH-1:0] step_mask,
  input  logic [NUM_STEPS-1:0]           step_rst,
  input  logic [LED_WIDTH-1:0]           led_in,
  output logic                           cpu_rst,
  output logic [SW_WIDTH-1:0]            sw_out,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [CNT_W-1:0]               fail_cnt,
  output logic [CNT_W-1:0]               fail_step
);

  localparam int unsigned TMR_MAX = (RESET_HOLD > SETTLE_CYC) ? RESET_HOLD : SETTLE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(RESET_HOLD - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

`ifdef IO_TEST_FAIL_HALT_EN
  localparam bit HALT_ON_FAIL = 1'b1;
`else
  localparam bit HALT_ON_FAIL = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      idx_q, idx_d, nxt_idx, last_idx;
  logic [SW_WIDTH-1:0]   sw_d, sw_nxt;
  logic [LED_WIDTH-1:0]  exp_sel, mask_sel;
  logic [CNT_W-1:0]      cnt_d, fstep_d;
  logic                  cpu_rst_d, busy_d, done_d, pass_d;
  logic                  rst_nxt, mismatch, tmr_load, tmr_zero;
  logic [TMR_W-1:0]      tmr_val;

  io_test_cycle_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Index of the final step: 0 runs one step, oversize counts clamp to the table.
  always_comb begin
    if (num_steps == '0) begin
      last_idx = '0;
    end else if (num_steps > CNT_W'(NUM_STEPS)) begin
      last_idx = CNT_W'(NUM_STEPS - 1);
    end else begin
      last_idx = num_steps - CNT_W'(1);
    end
  end

  assign nxt_idx = idx_q + CNT_W'(1);

  // Table lookups for the step being checked and the step that follows it.
  always_comb begin
    exp_sel  = '0;
    mask_sel = '0;
    sw_nxt   = '0;
    rst_nxt  = 1'b0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (idx_q == CNT_W'(i)) begin
        exp_sel  = step_exp[i*LED_WIDTH +: LED_WIDTH];
        mask_sel = step_mask[i*LED_WIDTH +: LED_WIDTH];
      end
      if (nxt_idx == CNT_W'(i)) begin
        sw_nxt  = step_sw[i*SW_WIDTH +: SW_WIDTH];
        rst_nxt = step_rst[i];
      end
    end
  end

  assign mismatch = |((led_in ^ exp_sel) & mask_sel);

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sw_d      = sw_out;
    cpu_rst_d = cpu_rst;
    busy_d    = busy;
    done_d    = done;
    pass_d    = pass;
    cnt_d     = fail_cnt;
    fstep_d   = fail_step;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = HOLD;
          idx_d     = '0;
          cnt_d     = '0;
          fstep_d   = '0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          busy_d    = 1'b1;
          cpu_rst_d = 1'b1;
          sw_d      = step_sw[SW_WIDTH-1:0];
          tmr_load  = 1'b1;
          tmr_val   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d   = SETTLE;
          cpu_rst_d = 1'b0;
          tmr_load  = 1'b1;
          tmr_val   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (tmr_zero) state_d = CHECK;
      end
      CHECK: begin
        if (mismatch) begin
          if (fail_cnt == '0) fstep_d = idx_q;
          if (fail_cnt != CNT_W'(NUM_STEPS)) cnt_d = fail_cnt + CNT_W'(1);
        end
        if ((idx_q == last_idx) || (HALT_ON_FAIL && mismatch)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (cnt_d == '0);
        end else begin
          idx_d    = nxt_idx;
          sw_d     = sw_nxt;
          tmr_load = 1'b1;
          if (rst_nxt) begin
            state_d   = HOLD;
            cpu_rst_d = 1'b1;
            tmr_val   = HOLD_LOAD;
          end else begin
            state_d = SETTLE;
            tmr_val = SETTLE_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sw_out    <= '0;
      cpu_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_cnt  <= '0;
      fail_step <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sw_out    <= sw_d;
      cpu_rst   <= cpu_rst_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_cnt  <= cnt_d;
      fail_step <= fstep_d;
    end
  end

endmodule
